// File: rtl/byte_pack_pkg.sv
// Shared types for the byte-to-word packer: assembly FSM states and lane geometry.
package byte_pack_pkg;
  localparam int LANES = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_PEND = 2'd2
  } state_t;
endpackage

// File: rtl/byte_pack_tmo.sv
// Idle counter for a partially filled word; pulses expire on the edge that should auto-flush.
module byte_pack_tmo #(
  parameter int TIMEOUT = 16
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      logic [TW-1:0] cnt_q;
      logic          hit;

      assign hit    = (cnt_q == TW'(TIMEOUT - 1));
      assign expire = en && !clr && hit;

      // Holds at the terminal value; the word always leaves FILL when expire fires.
      always_ff @(posedge sclk) begin
        if (!rst_n || !en || clr) cnt_q <= '0;
        else if (!hit)            cnt_q <= cnt_q + TW'(1);
      end
    end
  endgenerate
endmodule

// File: rtl/byte_pack32.sv
// Packs an 8-bit strobe stream little-endian into 32-bit words on a valid/ready port,
// with explicit/timeout flush of partial words and a sticky overflow for dropped bytes.
module byte_pack32
  import byte_pack_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             i_dv,
  input  logic [7:0]       i_data,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [31:0]      o_word,
  output logic [2:0]       o_bcnt,
  output logic             o_ovf,
  output logic [CNT_W-1:0] o_word_cnt
);
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] packed_w, load_word;
  logic [2:0]  nbytes, load_bcnt;
  logic        load, ovf_set, complete, slot_free, expire;

  byte_pack_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .sclk   (sclk),
    .rst_n  (rst_n),
    .en     (state_q == S_FILL),
    .clr    (i_dv),
    .expire (expire)
  );

  assign slot_free = !o_valid || o_ready;

  always_comb begin
    nbytes   = cnt_q + {2'b00, i_dv};
    packed_w = asm_q;
    for (int l = 0; l < LANES; l++)
      if (i_dv && cnt_q[1:0] == l[1:0]) packed_w[BYTE_W*l +: BYTE_W] = i_data;
    // Flush/timeout never produce an empty word; an i_dv byte is packed before flushing.
    complete  = (nbytes != 3'd0) && (nbytes == 3'd4 || i_flush || expire);

    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    load      = 1'b0;
    load_word = asm_q;
    load_bcnt = cnt_q;
    ovf_set   = 1'b0;

    case (state_q)
      S_IDLE, S_FILL: begin
        if (complete) begin
          load_word = packed_w;
          load_bcnt = nbytes;
          if (slot_free) begin
            load    = 1'b1;
            state_d = S_IDLE;
            cnt_d   = 3'd0;
            asm_d   = '0;
          end else begin
            state_d = S_PEND;
            cnt_d   = nbytes;
            asm_d   = packed_w;
          end
        end else begin
          asm_d   = packed_w;
          cnt_d   = nbytes;
          state_d = (nbytes != 3'd0) ? S_FILL : S_IDLE;
        end
      end
      S_PEND: begin
        if (slot_free) begin
          load = 1'b1;
          if (i_dv) begin
            asm_d   = {24'h0, i_data};
            cnt_d   = 3'd1;
            state_d = S_FILL;
          end else begin
            asm_d   = '0;
            cnt_d   = 3'd0;
            state_d = S_IDLE;
          end
        end else if (i_dv) begin
          ovf_set = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
        asm_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      asm_q      <= '0;
      o_valid    <= 1'b0;
      o_word     <= '0;
      o_bcnt     <= 3'd0;
      o_ovf      <= 1'b0;
      o_word_cnt <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      if (load) begin
        o_valid <= 1'b1;
        o_word  <= load_word;
        o_bcnt  <= load_bcnt;
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
      if (ovf_set)           o_ovf      <= 1'b1;
      if (o_valid && o_ready) o_word_cnt <= o_word_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_byte_pack32.sv
// Directed bench for byte_pack32: packing, timeout, backpressure/overflow, flush, reset, wrap.
module tb_byte_pack32;
  logic        sclk = 1'b0;
  logic        rst_n, i_dv, i_flush, o_valid, o_ready, o_ovf;
  logic [7:0]  i_data;
  logic [31:0] o_word;
  logic [2:0]  o_bcnt;
  logic [3:0]  o_word_cnt;
  int total = 0;
  int bad   = 0;

  byte_pack32 #(.TIMEOUT(16), .CNT_W(4)) dut (
    .sclk(sclk), .rst_n(rst_n), .i_dv(i_dv), .i_data(i_data), .i_flush(i_flush),
    .o_valid(o_valid), .o_ready(o_ready), .o_word(o_word), .o_bcnt(o_bcnt),
    .o_ovf(o_ovf), .o_word_cnt(o_word_cnt)
  );

  always #5 sclk = ~sclk;

  task automatic tick();
    @(posedge sclk); #1;
  endtask

  task automatic send(input logic [7:0] b, input logic fl);
    i_dv = 1'b1; i_data = b; i_flush = fl;
    tick();
    i_dv = 1'b0; i_flush = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_dv = 1'b1; i_data = 8'hFF; i_flush = 1'b1; o_ready = 1'b1;
    tick();
    i_dv = 1'b0; i_flush = 1'b0;
    total++; if ({o_valid, o_word, o_bcnt, o_ovf, o_word_cnt} !== 41'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {o_valid, o_word, o_bcnt, o_ovf, o_word_cnt}); end
    rst_n = 1'b1;
    tick();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_no_word got=%b want=0", o_valid); end
  endtask

  task automatic test_pattern();
    do_reset(); o_ready = 1'b1;
    send(8'h07, 0); send(8'h05, 0); send(8'h07, 0);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL pat_early got=%b want=0", o_valid); end
    send(8'h05, 0);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL pat_valid got=%b want=1", o_valid); end
    total++; if (o_word !== 32'h05070507) begin bad++; $display("FAIL pat_word got=%h want=05070507", o_word); end
    total++; if (o_bcnt !== 3'd4) begin bad++; $display("FAIL pat_bcnt got=%0d want=4", o_bcnt); end
    send(8'h07, 0);
    total++; if (o_word_cnt !== 4'd1) begin bad++; $display("FAIL pat_cnt got=%0d want=1", o_word_cnt); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL pat_drop_valid got=%b want=0", o_valid); end
    send(8'h05, 0); tick(); tick();
    total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL pat_ovf got=%b want=0", o_ovf); end
  endtask

  task automatic test_timeout();
    do_reset(); o_ready = 1'b1;
    send(8'hAA, 0); send(8'hBB, 0);
    for (int k = 0; k < 15; k++) tick();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b want=0", o_valid); end
    tick();
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL tmo_valid got=%b want=1", o_valid); end
    total++; if (o_word !== 32'h0000BBAA) begin bad++; $display("FAIL tmo_word got=%h want=0000bbaa", o_word); end
    total++; if (o_bcnt !== 3'd2) begin bad++; $display("FAIL tmo_bcnt got=%0d want=2", o_bcnt); end
  endtask

  task automatic test_backpressure();
    do_reset(); o_ready = 1'b0;
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    send(8'h05, 0); send(8'h06, 0); send(8'h07, 0); send(8'h08, 0);
    total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL bp_ovf_early got=%b want=0", o_ovf); end
    send(8'h09, 0);
    total++; if (o_ovf !== 1'b1) begin bad++; $display("FAIL bp_ovf got=%b want=1", o_ovf); end
    total++; if (o_word !== 32'h04030201 || o_valid !== 1'b1) begin
      bad++; $display("FAIL bp_hold got=%b/%h want=1/04030201", o_valid, o_word); end
    o_ready = 1'b1;
    send(8'h0A, 0);
    total++; if (o_valid !== 1'b1 || o_word !== 32'h08070605 || o_bcnt !== 3'd4) begin
      bad++; $display("FAIL bp_second got=%b/%h/%0d want=1/08070605/4", o_valid, o_word, o_bcnt); end
    total++; if (o_word_cnt !== 4'd1) begin bad++; $display("FAIL bp_cnt1 got=%0d want=1", o_word_cnt); end
    send(8'h0B, 0);
    total++; if (o_valid !== 1'b0 || o_word_cnt !== 4'd2) begin
      bad++; $display("FAIL bp_drain got=%b/%0d want=0/2", o_valid, o_word_cnt); end
    send(8'h0C, 0); send(8'h0D, 0);
    total++; if (o_valid !== 1'b1 || o_word !== 32'h0D0C0B0A) begin
      bad++; $display("FAIL bp_lane0_keep got=%b/%h want=1/0d0c0b0a", o_valid, o_word); end
    tick();
    total++; if (o_word_cnt !== 4'd3 || o_ovf !== 1'b1) begin
      bad++; $display("FAIL bp_final got=%0d/%b want=3/1", o_word_cnt, o_ovf); end
  endtask

  task automatic test_flush();
    do_reset(); o_ready = 1'b1;
    send(8'h11, 0); send(8'h22, 0); send(8'hCC, 1);
    total++; if (o_valid !== 1'b1 || o_word !== 32'h00CC2211 || o_bcnt !== 3'd3) begin
      bad++; $display("FAIL fl_partial got=%b/%h/%0d want=1/00cc2211/3", o_valid, o_word, o_bcnt); end
    tick();
    i_flush = 1'b1; tick(); i_flush = 1'b0;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL fl_idle got=%b want=0", o_valid); end
    tick();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL fl_idle2 got=%b want=0", o_valid); end
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
    total++; if (o_valid !== 1'b1 || o_word !== 32'h04030201 || o_bcnt !== 3'd4) begin
      bad++; $display("FAIL fl_full got=%b/%h/%0d want=1/04030201/4", o_valid, o_word, o_bcnt); end
    tick();
    total++; if (o_word_cnt !== 4'd2) begin bad++; $display("FAIL fl_cnt got=%0d want=2", o_word_cnt); end
  endtask

  task automatic test_midword_reset();
    int seen;
    do_reset(); o_ready = 1'b1;
    send(8'h01, 0); send(8'h02, 0);
    rst_n = 1'b0; tick();
    total++; if ({o_valid, o_word, o_bcnt, o_ovf, o_word_cnt} !== 41'h0) begin
      bad++; $display("FAIL mr_outputs got=%h want=0", {o_valid, o_word, o_bcnt, o_ovf, o_word_cnt}); end
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (o_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL mr_ghost got=%0d want=0", seen); end
    send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0); send(8'hA4, 0);
    total++; if (o_valid !== 1'b1 || o_word !== 32'hA4A3A2A1 || o_bcnt !== 3'd4) begin
      bad++; $display("FAIL mr_clean got=%b/%h/%0d want=1/a4a3a2a1/4", o_valid, o_word, o_bcnt); end
  endtask

  task automatic test_back_to_back();
    int words, errs;
    logic [7:0]  b;
    logic [31:0] exp_w;
    do_reset(); o_ready = 1'b1;
    words = 0; errs = 0;
    for (int w = 0; w < 16; w++) begin
      for (int j = 0; j < 4; j++) begin
        b = 8'(4 * w + j);
        send(b, 0);
      end
      exp_w = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      if (o_valid === 1'b1) words++;
      if (o_word !== exp_w) errs++;
      if (w == 15) begin
        total++; if (o_word_cnt !== 4'd15) begin bad++; $display("FAIL b2b_pre got=%0d want=15", o_word_cnt); end
      end
    end
    total++; if (words !== 16 || errs !== 0) begin
      bad++; $display("FAIL b2b_words got=%0d/%0d want=16/0", words, errs); end
    tick();
    total++; if (o_word_cnt !== 4'd0) begin bad++; $display("FAIL b2b_wrap got=%0d want=0", o_word_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; i_dv = 1'b0; i_data = 8'h00; i_flush = 1'b0; o_ready = 1'b0;
    test_reset();
    test_pattern();
    test_timeout();
    test_backpressure();
    test_flush();
    test_midword_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
